// File: rtl/queue_dequeue_client_if.sv
// rtl/queue_dequeue_client_if.sv - handshake bundle between the dequeue client and its partners
// master: the dequeue client (consumes cmd/resp/done, drives req/desc/commit)
// slave : the front end, queue manager and consumer side
interface queue_dequeue_client_if #(
    parameter int QUEUE_INDEX_WIDTH = 8,
    parameter int REQ_TAG_WIDTH     = 8,
    parameter int OP_TAG_WIDTH      = 6,
    parameter int QUEUE_PTR_WIDTH   = 16,
    parameter int ADDR_WIDTH        = 64
);
    logic [QUEUE_INDEX_WIDTH-1:0] s_axis_cmd_queue;
    logic                         s_axis_cmd_valid;
    logic                         s_axis_cmd_ready;

    logic [QUEUE_INDEX_WIDTH-1:0] m_axis_dequeue_req_queue;
    logic [REQ_TAG_WIDTH-1:0]     m_axis_dequeue_req_tag;
    logic                         m_axis_dequeue_req_valid;
    logic                         m_axis_dequeue_req_ready;

    logic [QUEUE_INDEX_WIDTH-1:0] s_axis_dequeue_resp_queue;
    logic [QUEUE_PTR_WIDTH-1:0]   s_axis_dequeue_resp_ptr;
    logic [ADDR_WIDTH-1:0]        s_axis_dequeue_resp_addr;
    logic [REQ_TAG_WIDTH-1:0]     s_axis_dequeue_resp_tag;
    logic [OP_TAG_WIDTH-1:0]      s_axis_dequeue_resp_op_tag;
    logic                         s_axis_dequeue_resp_empty;
    logic                         s_axis_dequeue_resp_error;
    logic                         s_axis_dequeue_resp_valid;
    logic                         s_axis_dequeue_resp_ready;

    logic [QUEUE_INDEX_WIDTH-1:0] m_axis_desc_queue;
    logic [QUEUE_PTR_WIDTH-1:0]   m_axis_desc_ptr;
    logic [ADDR_WIDTH-1:0]        m_axis_desc_addr;
    logic                         m_axis_desc_valid;
    logic                         m_axis_desc_ready;

    logic                         s_axis_done_valid;
    logic                         s_axis_done_ready;

    logic [OP_TAG_WIDTH-1:0]      m_axis_dequeue_commit_op_tag;
    logic                         m_axis_dequeue_commit_valid;
    logic                         m_axis_dequeue_commit_ready;

    modport master (
        input  s_axis_cmd_queue, s_axis_cmd_valid,
        output s_axis_cmd_ready,
        output m_axis_dequeue_req_queue, m_axis_dequeue_req_tag, m_axis_dequeue_req_valid,
        input  m_axis_dequeue_req_ready,
        input  s_axis_dequeue_resp_queue, s_axis_dequeue_resp_ptr, s_axis_dequeue_resp_addr,
        input  s_axis_dequeue_resp_tag, s_axis_dequeue_resp_op_tag, s_axis_dequeue_resp_empty,
        input  s_axis_dequeue_resp_error, s_axis_dequeue_resp_valid,
        output s_axis_dequeue_resp_ready,
        output m_axis_desc_queue, m_axis_desc_ptr, m_axis_desc_addr, m_axis_desc_valid,
        input  m_axis_desc_ready,
        input  s_axis_done_valid,
        output s_axis_done_ready,
        output m_axis_dequeue_commit_op_tag, m_axis_dequeue_commit_valid,
        input  m_axis_dequeue_commit_ready
    );

    modport slave (
        output s_axis_cmd_queue, s_axis_cmd_valid,
        input  s_axis_cmd_ready,
        input  m_axis_dequeue_req_queue, m_axis_dequeue_req_tag, m_axis_dequeue_req_valid,
        output m_axis_dequeue_req_ready,
        output s_axis_dequeue_resp_queue, s_axis_dequeue_resp_ptr, s_axis_dequeue_resp_addr,
        output s_axis_dequeue_resp_tag, s_axis_dequeue_resp_op_tag, s_axis_dequeue_resp_empty,
        output s_axis_dequeue_resp_error, s_axis_dequeue_resp_valid,
        input  s_axis_dequeue_resp_ready,
        input  m_axis_desc_queue, m_axis_desc_ptr, m_axis_desc_addr, m_axis_desc_valid,
        output m_axis_desc_ready,
        output s_axis_done_valid,
        input  s_axis_done_ready,
        input  m_axis_dequeue_commit_op_tag, m_axis_dequeue_commit_valid,
        output m_axis_dequeue_commit_ready
    );
endinterface

// File: rtl/queue_dequeue_client.sv
// rtl/queue_dequeue_client.sv - one-at-a-time dequeue initiator: command, tagged request, descriptor, commit
// clk/rst   : rising-edge clock, asynchronous active-high reset
// enable    : allows a new command to be taken while idle
// bus       : cmd in, req out, resp in, desc out, done in, commit out (master side)
// busy      : high whenever an operation is in flight
// stat_*    : saturating counts of committed dequeues, empty responses, error/mismatched responses
module queue_dequeue_client #(
    parameter int QUEUE_INDEX_WIDTH = 8,
    parameter int REQ_TAG_WIDTH     = 8,
    parameter int OP_TAG_WIDTH      = 6,
    parameter int QUEUE_PTR_WIDTH   = 16,
    parameter int ADDR_WIDTH        = 64,
    parameter int STAT_WIDTH        = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    queue_dequeue_client_if.master bus,
    output logic                  busy,
    output logic [STAT_WIDTH-1:0] stat_dequeue_count,
    output logic [STAT_WIDTH-1:0] stat_empty_count,
    output logic [STAT_WIDTH-1:0] stat_error_count
);
    typedef enum logic [2:0] {
        IDLE, REQ, WAIT_RESP, DELIVER, WAIT_DONE, COMMIT
    } state_t;

    state_t                       state_q;
    logic [QUEUE_INDEX_WIDTH-1:0] queue_q;
    logic [REQ_TAG_WIDTH-1:0]     tag_q;
    logic [REQ_TAG_WIDTH-1:0]     tag_cnt_q;
    logic [QUEUE_PTR_WIDTH-1:0]   ptr_q;
    logic [ADDR_WIDTH-1:0]        addr_q;
    logic [OP_TAG_WIDTH-1:0]      op_tag_q;
    logic                         req_valid_q, resp_ready_q, desc_valid_q;
    logic                         done_ready_q, commit_valid_q, busy_q;
    logic [STAT_WIDTH-1:0]        stat_dequeue_q, stat_empty_q, stat_error_q;
    logic [STAT_WIDTH-1:0]        stat_dequeue_d, stat_empty_d, stat_error_d;

    // The response echoes the queue, but the descriptor always carries the issued queue.
    logic unused_resp_queue;
    assign unused_resp_queue = ^bus.s_axis_dequeue_resp_queue;

    // Saturating increments: hold at all-ones instead of wrapping.
    assign stat_dequeue_d = (stat_dequeue_q == '1) ? stat_dequeue_q : stat_dequeue_q + STAT_WIDTH'(1);
    assign stat_empty_d   = (stat_empty_q   == '1) ? stat_empty_q   : stat_empty_q   + STAT_WIDTH'(1);
    assign stat_error_d   = (stat_error_q   == '1) ? stat_error_q   : stat_error_q   + STAT_WIDTH'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            queue_q        <= '0;
            tag_q          <= '0;
            tag_cnt_q      <= '0;
            ptr_q          <= '0;
            addr_q         <= '0;
            op_tag_q       <= '0;
            req_valid_q    <= 1'b0;
            resp_ready_q   <= 1'b0;
            desc_valid_q   <= 1'b0;
            done_ready_q   <= 1'b0;
            commit_valid_q <= 1'b0;
            busy_q         <= 1'b0;
            stat_dequeue_q <= '0;
            stat_empty_q   <= '0;
            stat_error_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (enable && bus.s_axis_cmd_valid) begin
                        queue_q     <= bus.s_axis_cmd_queue;
                        tag_q       <= tag_cnt_q;
                        tag_cnt_q   <= tag_cnt_q + REQ_TAG_WIDTH'(1);
                        req_valid_q <= 1'b1;
                        busy_q      <= 1'b1;
                        state_q     <= REQ;
                    end
                end
                REQ: begin
                    if (bus.m_axis_dequeue_req_ready) begin
                        req_valid_q  <= 1'b0;
                        resp_ready_q <= 1'b1;
                        state_q      <= WAIT_RESP;
                    end
                end
                WAIT_RESP: begin
                    if (bus.s_axis_dequeue_resp_valid) begin
                        if (bus.s_axis_dequeue_resp_tag != tag_q) begin
                            // Stale or foreign beat: discard and keep waiting for ours.
                            stat_error_q <= stat_error_d;
                        end else if (bus.s_axis_dequeue_resp_error) begin
                            stat_error_q <= stat_error_d;
                            resp_ready_q <= 1'b0;
                            busy_q       <= 1'b0;
                            state_q      <= IDLE;
                        end else if (bus.s_axis_dequeue_resp_empty) begin
                            stat_empty_q <= stat_empty_d;
                            resp_ready_q <= 1'b0;
                            busy_q       <= 1'b0;
                            state_q      <= IDLE;
                        end else begin
                            ptr_q        <= bus.s_axis_dequeue_resp_ptr;
                            addr_q       <= bus.s_axis_dequeue_resp_addr;
                            op_tag_q     <= bus.s_axis_dequeue_resp_op_tag;
                            resp_ready_q <= 1'b0;
                            desc_valid_q <= 1'b1;
                            state_q      <= DELIVER;
                        end
                    end
                end
                DELIVER: begin
                    if (bus.m_axis_desc_ready) begin
                        desc_valid_q <= 1'b0;
                        done_ready_q <= 1'b1;
                        state_q      <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    if (bus.s_axis_done_valid) begin
                        done_ready_q   <= 1'b0;
                        commit_valid_q <= 1'b1;
                        state_q        <= COMMIT;
                    end
                end
                COMMIT: begin
                    if (bus.m_axis_dequeue_commit_ready) begin
                        commit_valid_q <= 1'b0;
                        stat_dequeue_q <= stat_dequeue_d;
                        busy_q         <= 1'b0;
                        state_q        <= IDLE;
                    end
                end
                default: begin
                    req_valid_q    <= 1'b0;
                    resp_ready_q   <= 1'b0;
                    desc_valid_q   <= 1'b0;
                    done_ready_q   <= 1'b0;
                    commit_valid_q <= 1'b0;
                    busy_q         <= 1'b0;
                    state_q        <= IDLE;
                end
            endcase
        end
    end

    assign bus.s_axis_cmd_ready             = enable && (state_q == IDLE);
    assign bus.m_axis_dequeue_req_queue     = queue_q;
    assign bus.m_axis_dequeue_req_tag       = tag_q;
    assign bus.m_axis_dequeue_req_valid     = req_valid_q;
    assign bus.s_axis_dequeue_resp_ready    = resp_ready_q;
    assign bus.m_axis_desc_queue            = queue_q;
    assign bus.m_axis_desc_ptr              = ptr_q;
    assign bus.m_axis_desc_addr             = addr_q;
    assign bus.m_axis_desc_valid            = desc_valid_q;
    assign bus.s_axis_done_ready            = done_ready_q;
    assign bus.m_axis_dequeue_commit_op_tag = op_tag_q;
    assign bus.m_axis_dequeue_commit_valid  = commit_valid_q;
    assign busy                             = busy_q;
    assign stat_dequeue_count               = stat_dequeue_q;
    assign stat_empty_count                 = stat_empty_q;
    assign stat_error_count                 = stat_error_q;
endmodule

// File: doc/queue_dequeue_client.md
# queue_dequeue_client

Initiator for the queue manager's dequeue protocol. Accepts a dequeue command naming a queue, issues a tagged dequeue request, and checks the response against the issued tag. A valid descriptor is handed to a downstream consumer; once the consumer signals done, the block issues the commit for the returned operation tag. It sits between a DMA/scheduler front end and the queue manager's dequeue request, response and commit ports, and handles one operation at a time.

## Interface
- QUEUE_INDEX_WIDTH, 8, queue index width
- REQ_TAG_WIDTH, 8, dequeue request tag width
- OP_TAG_WIDTH, 6, commit operation tag width
- QUEUE_PTR_WIDTH, 16, queue pointer width
- ADDR_WIDTH, 64, descriptor address width
- STAT_WIDTH, 32, statistics counter width

Ports:
- clk  in  1  clock; all logic on the rising edge
- rst  in  1  reset, asynchronous, active-high
- enable  in  1  permits acceptance of new commands
- s_axis_cmd_queue / _valid / _ready  in / in / out  QUEUE_INDEX_WIDTH / 1 / 1  dequeue command
- m_axis_dequeue_req_queue / _tag / _valid / _ready  out / out / out / in  QUEUE_INDEX_WIDTH / REQ_TAG_WIDTH / 1 / 1  request to the queue manager
- s_axis_dequeue_resp_queue / _ptr / _addr / _tag / _op_tag / _empty / _error / _valid / _ready  in×8, out  QUEUE_INDEX_WIDTH / QUEUE_PTR_WIDTH / ADDR_WIDTH / REQ_TAG_WIDTH / OP_TAG_WIDTH / 1 / 1 / 1 / 1  response from the queue manager
- m_axis_desc_queue / _ptr / _addr / _valid / _ready  out×4, in  QUEUE_INDEX_WIDTH / QUEUE_PTR_WIDTH / ADDR_WIDTH / 1 / 1  descriptor to the consumer
- s_axis_done_valid / _ready  in / out  1 / 1  consumer completion
- m_axis_dequeue_commit_op_tag / _valid / _ready  out / out / in  OP_TAG_WIDTH / 1 / 1  commit to the queue manager
- busy  out  1  high in any state other than IDLE
- stat_dequeue_count, stat_empty_count, stat_error_count  out  STAT_WIDTH each  statistics counters

## Operation
- **States:** IDLE, REQ, WAIT_RESP, DELIVER, WAIT_DONE, COMMIT.
- **IDLE:** s_axis_cmd_ready = enable. When the command handshakes, latch the queue, drive the request tag from the tag counter, increment the counter, and go to REQ.
- **REQ:** req_valid = 1. queue and tag are held stable until req_ready. Then go to WAIT_RESP.
- **WAIT_RESP:** resp_ready = 1. On a response beat:
  - tag ≠ issued tag: drop the beat, increment stat_error, stay in WAIT_RESP.
  - error = 1: increment stat_error, go to IDLE. error takes priority over empty.
  - empty = 1: increment stat_empty, go to IDLE. No commit is issued.
  - otherwise: latch ptr, addr and op_tag, and go to DELIVER. The latched queue is the issued queue, not resp_queue.
- **DELIVER:** desc_valid = 1 with the latched fields until desc_ready, then go to WAIT_DONE.
- **WAIT_DONE:** done_ready = 1. On done_valid, go to COMMIT.
- **COMMIT:** commit_valid = 1 with the latched op_tag until commit_ready. Then increment stat_dequeue and go to IDLE.
- **Tag counter:** resets to 0, increments by 1 per issued request, wraps modulo 2^REQ_TAG_WIDTH.
- **Counters:** saturate at all-ones and do not wrap.
- **enable low:** gates only command acceptance in IDLE. An in-flight operation runs to completion.
- **Valid/ready outputs:** decoded from the state register only, never from same-cycle inputs.
- **Payload outputs:** held at their last latched values outside their valid phase.

## Timing
- **Reset (asynchronous, immediate):** state = IDLE; tag counter, all latched fields, all valid outputs, busy and all counters = 0. s_axis_cmd_ready = enable.
- **Reset mid-operation:** abandons the operation. No commit is issued, and no request or descriptor valid persists after reset asserts.
- **Per-stage latency:** a handshake at edge N makes the next stage's valid/ready high in cycle N+1.
  - command accepted → req_valid
  - req accepted → resp_ready
  - response accepted → desc_valid
  - desc accepted → done_ready
  - done accepted → commit_valid
- **Best-case throughput:** with all partners always ready and an immediate response, a command accepted in cycle 0 produces commit_valid in cycle 5. cmd_ready returns high in cycle 6, giving one operation per 6 cycles.
- **Back-pressure:** any wait on a partner adds cycles without limit.
- **Counter updates:** visible the cycle after the triggering handshake.

## Test plan
- **Normal dequeue:** reset, then cmd queue=3 with all ready high, response tag=0 op_tag=5 ptr=0x10 addr=0x1000 empty=0 error=0 → req queue=3 tag=0; desc 3/0x10/0x1000; commit op_tag=5 in cycle 5; stat_dequeue=1.
- **Empty response:** cmd queue=7, response empty=1 → no desc and no commit; stat_empty=1; back in IDLE the cycle after the response.
- **Tag mismatch then match:** issued tag=1; response tag=2 is dropped with stat_error=1; then a response with tag=1 → desc delivered and commit issued.
- **Back-pressure and tag wrap:** hold req_ready, desc_ready and commit_ready low for 10 cycles each → payloads stay stable. After 256 commands the tag returns to 0.
- **Reset and enable:** assert rst in WAIT_DONE → busy=0, commit_valid never asserts, counters=0. With enable=0 in IDLE, cmd_ready=0 and a pending command is not accepted.
